conv_window_gen: RTL

//   Streaming 3x3 sliding-window generator feeding the PE array's ifm inputs.

---
 rtl/conv_window_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator, stride 1, no padding.
// Raster pixels in, one complete window out per interior pixel.
module conv_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int WIN_SIZE   = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          pix_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] win_data,
  output logic                           frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic {FILL, RUN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  win_valid_q, win_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win_q [WIN_SIZE];
  logic                  acc;
  logic                  col_last;
  logic                  row_last;

  assign in_ready   = rst_n && (!win_valid_q || win_ready);
  assign acc        = in_valid && in_ready;
  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  for (genvar i = 0; i < WIN_SIZE; i++) begin : g_pack
    assign win_data[i*DATA_WIDTH +: DATA_WIDTH] = win_q[i];
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q && !win_ready;
    frame_done_d = 1'b0;
    if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + CW'(1);
      end
      unique case (state_q)
        FILL: begin
          if (col_last && row_q == ROW_ONE) state_d = RUN;
        end
        RUN: begin
          if (col_q >= COL_MIN) win_valid_d = 1'b1;
          if (col_last && row_last) begin
            state_d      = FILL;
            frame_done_d = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shift window left, new column is {row r-2, row r-1, incoming pixel}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_SIZE; i++) win_q[i] <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r*3]   <= win_q[r*3+1];
        win_q[r*3+1] <= win_q[r*3+2];
      end
      win_q[2]     <= lb2_q[col_q];
      win_q[5]     <= lb1_q[col_q];
      win_q[8]     <= pix_data;
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_data;
    end
  end

endmodule
